// File: rtl/usbf_tx_packetizer.sv
// USB device transmit packetizer: emits PID, optional FIFO payload and inverted
// CRC16 towards the UTMI transmit port, reporting done/underrun to the protocol engine.
module usbf_tx_packetizer #(
  parameter int LEN_W = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tx_start_i,
  input  logic [7:0]       tx_pid_i,
  input  logic             tx_data_pkt_i,
  input  logic [LEN_W-1:0] tx_len_i,
  input  logic [7:0]       fifo_data_i,
  input  logic             fifo_empty_i,
  output logic             fifo_pop_o,
  output logic [7:0]       utmi_data_o,
  output logic             utmi_txvalid_o,
  input  logic             utmi_txready_i,
  output logic             tx_busy_o,
  output logic             tx_done_o,
  output logic             tx_underrun_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       pid_q, pid_d;
  logic             data_pkt_q, data_pkt_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [15:0]      crc_q, crc_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;

  // CRC-16/USB, reflected polynomial 0xA001, one byte processed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  always_comb begin
    state_d        = state_q;
    pid_d          = pid_q;
    data_pkt_d     = data_pkt_q;
    rem_d          = rem_q;
    crc_d          = crc_q;
    done_d         = 1'b0;
    underrun_d     = 1'b0;
    utmi_data_o    = 8'h00;
    utmi_txvalid_o = 1'b0;
    fifo_pop_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_start_i) begin
          pid_d      = tx_pid_i;
          data_pkt_d = tx_data_pkt_i;
          rem_d      = tx_len_i;
          crc_d      = 16'hFFFF;
          state_d    = S_PID;
        end
      end
      S_PID: begin
        utmi_data_o    = pid_q;
        utmi_txvalid_o = 1'b1;
        if (utmi_txready_i) begin
          if (!data_pkt_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (rem_q == '0) begin
            state_d = S_CRC_LO;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        utmi_data_o    = fifo_data_i;
        utmi_txvalid_o = !fifo_empty_i;
        // An empty FIFO mid-payload aborts: txvalid is already low this cycle.
        if (fifo_empty_i) begin
          state_d    = S_IDLE;
          underrun_d = 1'b1;
        end else if (utmi_txready_i) begin
          fifo_pop_o = 1'b1;
          crc_d      = crc16_byte(crc_q, fifo_data_i);
          rem_d      = (rem_q != '0) ? rem_q - 1'b1 : '0;
          if (rem_q <= LEN_W'(1)) state_d = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        utmi_data_o    = ~crc_q[7:0];
        utmi_txvalid_o = 1'b1;
        if (utmi_txready_i) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        utmi_data_o    = ~crc_q[15:8];
        utmi_txvalid_o = 1'b1;
        if (utmi_txready_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pid_q      <= 8'h00;
      data_pkt_q <= 1'b0;
      rem_q      <= '0;
      crc_q      <= 16'hFFFF;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      data_pkt_q <= data_pkt_d;
      rem_q      <= rem_d;
      crc_q      <= crc_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign tx_busy_o     = (state_q != S_IDLE);
  assign tx_done_o     = done_q;
  assign tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_usbf_tx_packetizer.sv
// Self-checking bench for usbf_tx_packetizer: FIFO model, random UTMI backpressure
// and a byte-stream reference model derived from the packet format rules.
module tb_usbf_tx_packetizer;
  localparam int LEN_W = 11;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             tx_start_i;
  logic [7:0]       tx_pid_i;
  logic             tx_data_pkt_i;
  logic [LEN_W-1:0] tx_len_i;
  logic [7:0]       fifo_data_i;
  logic             fifo_empty_i;
  logic             fifo_pop_o;
  logic [7:0]       utmi_data_o;
  logic             utmi_txvalid_o;
  logic             utmi_txready_i;
  logic             tx_busy_o;
  logic             tx_done_o;
  logic             tx_underrun_o;

  usbf_tx_packetizer #(.LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tx_start_i(tx_start_i), .tx_pid_i(tx_pid_i),
    .tx_data_pkt_i(tx_data_pkt_i), .tx_len_i(tx_len_i), .fifo_data_i(fifo_data_i),
    .fifo_empty_i(fifo_empty_i), .fifo_pop_o(fifo_pop_o), .utmi_data_o(utmi_data_o),
    .utmi_txvalid_o(utmi_txvalid_o), .utmi_txready_i(utmi_txready_i),
    .tx_busy_o(tx_busy_o), .tx_done_o(tx_done_o), .tx_underrun_o(tx_underrun_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model: circular byte store, head presented combinationally.
  logic [7:0] mem [0:255];
  logic [7:0] rd = 8'd0;
  logic [7:0] wr = 8'd0;
  assign fifo_data_i  = mem[rd];
  assign fifo_empty_i = (rd == wr);

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] pay [$];
  logic [7:0] got [$];
  int   n_pop, n_done, n_und;
  logic pop_s = 1'b0, prev_vld = 1'b0, prev_rdy = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC-16/USB of the first n bytes of the payload, straight from the bit rule.
  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] c = 16'hFFFF;
    logic fb;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pay[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    return c;
  endfunction

  task automatic sample();
    @(negedge clk_i);
    if (prev_vld && !prev_rdy && utmi_txvalid_o) chk("data_hold", utmi_data_o, prev_data);
    if (fifo_pop_o) chk("pop_only_on_accept", utmi_txvalid_o & utmi_txready_i, 1'b1);
    if (tx_underrun_o) chk("txvalid_low_before_underrun", prev_vld, 1'b0);
    if (utmi_txvalid_o && utmi_txready_i) got.push_back(utmi_data_o);
    n_pop  += int'(fifo_pop_o);
    n_done += int'(tx_done_o);
    n_und  += int'(tx_underrun_o);
    pop_s     = fifo_pop_o;
    prev_vld  = utmi_txvalid_o;
    prev_rdy  = utmi_txready_i;
    prev_data = utmi_data_o;
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
    if (pop_s) rd++;
    pop_s = 1'b0;
  endtask

  // Runs one packet; returns positioned at the negedge of the done/underrun cycle.
  task automatic run_pkt(input logic [7:0] pid, input bit dp, input int len,
                         input bit rnd, input bit b2b);
    logic [7:0] exp [$];
    logic [15:0] c;
    bit fin = 1'b0;
    int n_send;
    bit und;
    foreach (pay[i]) begin
      mem[wr] = pay[i];
      wr++;
    end
    got.delete();
    n_pop = 0; n_done = 0; n_und = 0;
    tx_start_i = 1'b1; tx_pid_i = pid; tx_data_pkt_i = dp; tx_len_i = LEN_W'(len);
    utmi_txready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!b2b) begin
      sample();
      chk("start_cycle_txvalid", utmi_txvalid_o, 1'b0);
      chk("start_cycle_busy", tx_busy_o, 1'b0);
    end
    advance();
    tx_start_i = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      sample();
      if (cyc == 0) begin
        chk("pid_txvalid", utmi_txvalid_o, 1'b1);
        chk("pid_byte", utmi_data_o, pid);
        chk("pid_busy", tx_busy_o, 1'b1);
      end
      if (tx_done_o || tx_underrun_o) fin = 1'b1;
      else begin
        advance();
        utmi_txready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tx_busy_o && $urandom_range(0, 3) == 0) begin
          tx_start_i = 1'b1; tx_pid_i = 8'($urandom);
          tx_data_pkt_i = 1'($urandom); tx_len_i = LEN_W'($urandom_range(0, 20));
        end else tx_start_i = 1'b0;
      end
    end
    tx_start_i = 1'b0;
    if (!fin) chk("packet_timeout", 1'b0, 1'b1);
    und    = dp && (pay.size() < len);
    n_send = !dp ? 0 : (und ? pay.size() : len);
    exp.push_back(pid);
    for (int i = 0; i < n_send; i++) exp.push_back(pay[i]);
    if (dp && !und) begin
      c = ~ref_crc(len);
      exp.push_back(c[7:0]);
      exp.push_back(c[15:8]);
    end
    chk("stream_len", got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk($sformatf("stream_byte[%0d]", i), got[i], exp[i]);
    chk("pop_count", n_pop, n_send);
    chk("done_count", n_done, !und);
    chk("underrun_count", n_und, und);
  endtask

  task automatic idle_check();
    advance();
    sample();
    chk("done_single_pulse", tx_done_o, 1'b0);
    chk("underrun_single_pulse", tx_underrun_o, 1'b0);
    chk("idle_busy", tx_busy_o, 1'b0);
    chk("idle_txvalid", utmi_txvalid_o, 1'b0);
    chk("idle_data", utmi_data_o, 8'h00);
    advance();
    rd = wr;
  endtask

  initial begin
    int len, nb;
    logic [7:0] p;
    bit dp;
    rst_i = 1'b1; tx_start_i = 1'b0; tx_pid_i = 8'h00; tx_data_pkt_i = 1'b0;
    tx_len_i = '0; utmi_txready_i = 1'b0;
    #1;
    chk("rst_txvalid", utmi_txvalid_o, 1'b0);
    chk("rst_data", utmi_data_o, 8'h00);
    chk("rst_pop", fifo_pop_o, 1'b0);
    chk("rst_busy", tx_busy_o, 1'b0);
    chk("rst_done", tx_done_o, 1'b0);
    chk("rst_underrun", tx_underrun_o, 1'b0);
    advance();
    advance();
    rst_i = 1'b0;

    // Handshake, zero-length packet, reference payload with and without backpressure.
    pay.delete();
    run_pkt(8'hD2, 1'b0, 0, 1'b0, 1'b0);
    idle_check();
    run_pkt(8'hC3, 1'b1, 0, 1'b0, 1'b0);
    idle_check();
    for (int r = 0; r < 2; r++) begin
      pay.delete();
      for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
      run_pkt(8'h4B, 1'b1, 9, r[0], 1'b0);
      if (got.size() == 12) begin
        chk("check_crc_lo", got[10], 8'hC8);
        chk("check_crc_hi", got[11], 8'hB4);
      end
      chk("fifo_drained", fifo_empty_i, 1'b1);
      idle_check();
    end

    // Underrun: two bytes available against a length of four, then a ZLP.
    pay.delete();
    pay.push_back(8'($urandom));
    pay.push_back(8'($urandom));
    run_pkt(8'hC3, 1'b1, 4, 1'b0, 1'b0);
    idle_check();
    pay.delete();
    run_pkt(8'h4B, 1'b1, 0, 1'b0, 1'b0);
    idle_check();

    // Random packets, some followed by a back-to-back handshake in the done cycle.
    for (int k = 0; k < 10; k++) begin
      p   = 8'($urandom);
      dp  = ($urandom_range(0, 3) != 0);
      len = dp ? $urandom_range(0, 10) : 0;
      nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len;
      pay.delete();
      for (int i = 0; i < nb; i++) pay.push_back(8'($urandom));
      run_pkt(p, dp, len, 1'b1, 1'b0);
      if (k % 3 == 0) begin
        pay.delete();
        run_pkt(8'h5A, 1'b0, 0, 1'b1, 1'b1);
      end
      idle_check();
    end

    // Reset in the middle of the payload.
    pay.delete();
    for (int i = 0; i < 8; i++) pay.push_back(8'($urandom));
    foreach (pay[i]) begin
      mem[wr] = pay[i];
      wr++;
    end
    got.delete();
    tx_start_i = 1'b1; tx_pid_i = 8'hC3; tx_data_pkt_i = 1'b1; tx_len_i = LEN_W'(8);
    utmi_txready_i = 1'b1;
    advance();
    tx_start_i = 1'b0;
    for (int cyc = 0; cyc < 50 && got.size() < 4; cyc++) begin
      sample();
      if (got.size() < 4) advance();
    end
    chk("pre_reset_bytes", got.size(), 4);
    chk("pre_reset_busy", tx_busy_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("async_rst_txvalid", utmi_txvalid_o, 1'b0);
    chk("async_rst_busy", tx_busy_o, 1'b0);
    chk("async_rst_pop", fifo_pop_o, 1'b0);
    chk("async_rst_data", utmi_data_o, 8'h00);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    rd = wr; pop_s = 1'b0; prev_vld = 1'b0;
    sample();
    chk("post_rst_done", tx_done_o, 1'b0);
    chk("post_rst_underrun", tx_underrun_o, 1'b0);
    chk("post_rst_busy", tx_busy_o, 1'b0);
    advance();
    pay.delete();
    run_pkt(8'hC3, 1'b1, 0, 1'b1, 1'b0);
    idle_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
